fetch_queue: RTL



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 73 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared sizing and entry layout for the instruction fetch queue.
package fetch_pkg;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 32;
  localparam int IMEM_AW = 8;
  localparam int INSTR_W = 32;
  localparam int PTR_W   = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a clear that beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output logic [PTR_W:0]   count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != (PTR_W+1)'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head never shows X before the first write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Fetch buffer: issues PC reads to the synchronous imem and queues {pc, instr} for decode.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [15:0]        fetch_cnt
);

  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [15:0]     fetch_cnt_q, fetch_cnt_d;
  logic [PTR_W:0]  fifo_count;
  logic [PTR_W+1:0] credits_used;
  logic            accept, push, pop;
  fetch_entry_t    push_entry, head_entry;

  fetch_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (head_entry)
  );

  // The in-flight read reserves a slot, so a returning word always has room.
  always_comb begin
    credits_used     = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, inflight_q};
    pc_ready         = !reset && !flush && (credits_used < (PTR_W+2)'(DEPTH));
    accept           = pc_valid && pc_ready;
    instr_valid      = !reset && (fifo_count != '0);
    pop              = instr_valid && instr_ready && !flush;
    push             = inflight_q && !flush;
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = imem_rdata;
    inflight_d       = accept;
    inflight_pc_d    = accept ? pc_in : inflight_pc_q;
    fetch_cnt_d      = pop ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_cnt_q   <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign imem_en   = accept;
  assign imem_addr = pc_in[IMEM_AW-1:0];
  assign instr     = head_entry.instr;
  assign instr_pc  = head_entry.pc;
  assign fetch_cnt = fetch_cnt_q;

endmodule
